// File: rtl/fft_input_loader.sv
// Loads a frame of complex samples into the FFT data RAM in bit-reversed
// order, then starts the FFT and locks input until it reports completion.
module fft_input_loader #(
    parameter int bit_width = 29,
    parameter int in_width  = 16,
    parameter int SHIFT     = 0,
    parameter int N         = 16,
    parameter int SIZE      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [in_width-1:0]  in_re,
    input  logic signed [in_width-1:0]  in_im,
    input  logic                        fft_done,
    output logic                        wr_en,
    output logic [SIZE:0]               wr_addr,
    output logic signed [bit_width-1:0] wr_re,
    output logic signed [bit_width-1:0] wr_im,
    output logic                        flag_start_FFT,
    output logic                        busy
);

    typedef enum logic [1:0] {LOAD, FLUSH, START, BUSY} state_t;

    localparam logic [SIZE-1:0] LAST = SIZE'(N - 1);

    state_t                      state;
    logic [SIZE-1:0]             cnt;
    logic [SIZE-1:0]             cnt_rev;
    logic                        accept;
    logic signed [bit_width-1:0] ext_re;
    logic signed [bit_width-1:0] ext_im;

    assign accept = in_valid && in_ready;

    // Sign-extend to the internal width, then scale up by SHIFT.
    assign ext_re = bit_width'(in_re) << SHIFT;
    assign ext_im = bit_width'(in_im) << SHIFT;

    // Bit-reversed RAM address of the current sample index.
    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < SIZE; i++) begin
            cnt_rev[i] = cnt[SIZE-1-i];
        end
    end

    // Frame loader FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= LOAD;
            cnt            <= '0;
            in_ready       <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_re          <= '0;
            wr_im          <= '0;
            flag_start_FFT <= 1'b0;
            busy           <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    flag_start_FFT <= 1'b0;
                    busy           <= 1'b0;
                    wr_en          <= accept;
                    if (accept) begin
                        wr_addr <= {1'b0, cnt_rev};
                        wr_re   <= ext_re;
                        wr_im   <= ext_im;
                        cnt     <= cnt + 1'b1;
                    end
                    if (accept && cnt == LAST) begin
                        state    <= FLUSH;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                FLUSH: begin
                    wr_en          <= 1'b0;
                    flag_start_FFT <= 1'b1;
                    state          <= START;
                end
                START: begin
                    flag_start_FFT <= 1'b0;
                    busy           <= 1'b1;
                    state          <= BUSY;
                end
                BUSY: begin
                    if (fft_done) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: table frames, corner sequences and
// randomized traffic against a frame-level reference model.
module tb_fft_input_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        fft_done;

    logic        in_ready, wr_en, flag, busy;
    logic [4:0]  wr_addr;
    logic [28:0] wr_re, wr_im;
    logic        in_ready2, wr_en2, flag2, busy2;
    logic [4:0]  wr_addr2;
    logic [28:0] wr_re2, wr_im2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fft_input_loader #(.SHIFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .fft_done(fft_done),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_re(wr_re), .wr_im(wr_im),
        .flag_start_FFT(flag), .busy(busy)
    );

    fft_input_loader #(.SHIFT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_re(in_re), .in_im(in_im),
        .fft_done(fft_done),
        .wr_en(wr_en2), .wr_addr(wr_addr2),
        .wr_re(wr_re2), .wr_im(wr_im2),
        .flag_start_FFT(flag2), .busy(busy2)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference helpers: plain arithmetic.
    function automatic logic [28:0] ext(input logic [15:0] x,
                                        input int sh);
        int s;
        s = $signed(x);
        return 29'(s * (2 ** sh));
    endfunction

    function automatic logic [4:0] rev(input int k);
        int r = 0;
        int x = k;
        for (int i = 0; i < 4; i++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return 5'(r);
    endfunction

    // Frame-level model: samples taken so far, and cycles since full.
    int          m_k = 0;
    int          m_tail = 0;
    logic        m_ready = 0, m_en = 0, m_flag = 0, m_busy = 0;
    logic [4:0]  m_addr = 0;
    logic [28:0] m_re = 0, m_im = 0, m_re2 = 0, m_im2 = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [28:0] re, im, re2;
    } w_t;
    w_t wq[$];

    // Compare against the model, log writes, then advance the model.
    always @(negedge clk) begin
        logic [124:0] act, exp;
        bit acc;
        act = {in_ready, wr_en, wr_addr, wr_re, wr_im, flag, busy,
               wr_re2, wr_im2};
        if (!rst_n) exp = '0;
        else exp = {m_ready, m_en, m_addr, m_re, m_im, m_flag, m_busy,
                    m_re2, m_im2};
        chk("model", act, exp);
        if (rst_n && wr_en)
            wq.push_back('{wr_addr, wr_re, wr_im, wr_re2});
        if (!rst_n) begin
            m_k = 0; m_tail = 0; m_ready = 0; m_en = 0; m_flag = 0;
            m_busy = 0; m_addr = 0; m_re = 0; m_im = 0;
            m_re2 = 0; m_im2 = 0;
        end else if (m_tail == 0) begin
            acc = in_valid && m_ready;
            m_en = acc;
            m_ready = 1;
            if (acc) begin
                m_addr = rev(m_k);
                m_re = ext(in_re, 0);
                m_im = ext(in_im, 0);
                m_re2 = ext(in_re, 2);
                m_im2 = ext(in_im, 2);
                m_k++;
                if (m_k == 16) begin
                    m_tail = 1;
                    m_ready = 0;
                end
            end
        end else if (m_tail == 1) begin
            m_en = 0; m_flag = 1; m_tail = 2;
        end else if (m_tail == 2) begin
            m_flag = 0; m_busy = 1; m_tail = 3;
        end else if (fft_done) begin
            m_busy = 0; m_ready = 1; m_tail = 0; m_k = 0;
        end
    end

    typedef struct {
        logic [15:0] re, im;
        logic [4:0]  addr;
        logic [28:0] wre, wim, wre2;
    } vec_t;
    vec_t tab[16];

    task automatic load_ramp();
        int rt[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int k = 0; k < 16; k++) begin
            int nk = -k;
            tab[k] = '{16'(k), 16'(nk), 5'(rt[k]), 29'(k), 29'(nk),
                       29'(k * 4)};
        end
    endtask

    task automatic load_sext();
        vec_t s[4];
        int rt[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        s[0] = '{16'h8000, 16'h7FFF, 5'd0, 29'h1FFF8000, 29'h00007FFF,
                 29'h1FFE0000};
        s[1] = '{16'hFFFF, 16'h0001, 5'd0, 29'h1FFFFFFF, 29'h00000001,
                 29'h1FFFFFFC};
        s[2] = '{16'h7FFF, 16'h8000, 5'd0, 29'h00007FFF, 29'h1FFF8000,
                 29'h0001FFFC};
        s[3] = '{16'h0000, 16'hFFFF, 5'd0, 29'h00000000, 29'h1FFFFFFF,
                 29'h00000000};
        for (int k = 0; k < 16; k++) begin
            tab[k] = s[k % 4];
            tab[k].addr = 5'(rt[k]);
        end
    endtask

    task automatic send_range(input int lo, input int hi, input int gap);
        for (int i = lo; i <= hi; i++) begin
            bit got = 0;
            in_valid = 1;
            in_re = tab[i].re;
            in_im = tab[i].im;
            for (int t = 0; t < 64 && !got; t++) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk);
                #2;
            end
            if (!got) chk("send_timeout", 0, 1);
            if (gap > 0) begin
                in_valid = 0;
                repeat (gap) @(posedge clk);
                #2;
            end
        end
    endtask

    task automatic check_wq(input string nm);
        chk({nm, "_count"}, wq.size(), 16);
        for (int i = 0; i < 16 && i < wq.size(); i++) begin
            chk({nm, "_addr"}, wq[i].addr, tab[i].addr);
            chk({nm, "_re"}, wq[i].re, tab[i].wre);
            chk({nm, "_im"}, wq[i].im, tab[i].wim);
            chk({nm, "_re_sh2"}, wq[i].re2, tab[i].wre2);
        end
    endtask

    // Called at posedge+2 right after the 16th accept edge.
    task automatic post_frame(input string nm);
        @(negedge clk);
        chk({nm, "_flush"}, {wr_en, flag, busy, in_ready}, 4'b1000);
        @(negedge clk);
        chk({nm, "_start"}, {wr_en, flag, busy, in_ready}, 4'b0100);
        @(negedge clk);
        chk({nm, "_busy"}, {wr_en, flag, busy, in_ready}, 4'b0010);
    endtask

    task automatic pulse_done(input int n);
        fft_done = 1;
        repeat (n) @(posedge clk);
        #2;
        fft_done = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        rst_n = 0; in_valid = 0; in_re = 0; in_im = 0; fft_done = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {in_ready, wr_en, wr_addr, wr_re, wr_im,
                              flag, busy}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", in_ready, 1);
        #1;

        // Continuous ramp frame, input held valid through lockout.
        load_ramp();
        wq.delete();
        send_range(0, 15, 0);
        post_frame("ramp");
        check_wq("ramp");
        nw = wq.size();
        repeat (8) @(posedge clk);
        #2;
        chk("lockout_writes", wq.size(), nw);
        chk("lockout_ready", {in_ready, busy}, 2'b01);

        // Done held 3 cycles: single return to LOAD.
        in_valid = 0;
        fft_done = 1;
        @(posedge clk);
        #1;
        chk("done_return", {in_ready, busy}, 2'b10);
        repeat (2) @(posedge clk);
        #1;
        fft_done = 0;
        chk("done_held", {in_ready, busy, flag}, 3'b100);
        #1;

        // Sign extension / shift frame.
        load_sext();
        wq.delete();
        send_range(0, 15, 0);
        post_frame("sext");
        check_wq("sext");
        in_valid = 0;
        repeat (2) @(posedge clk);
        #2;
        pulse_done(1);

        // Bubbles: valid 1,0,0,1,...
        load_ramp();
        wq.delete();
        send_range(0, 15, 2);
        repeat (4) @(posedge clk);
        #2;
        check_wq("bubble");
        pulse_done(1);

        // Spurious done in LOAD after 5 accepts.
        wq.delete();
        send_range(0, 4, 0);
        in_valid = 0;
        pulse_done(1);
        chk("spurious_ready", {in_ready, busy}, 2'b10);
        send_range(5, 15, 0);
        post_frame("spurious");
        check_wq("spurious");
        in_valid = 0;
        pulse_done(1);

        // Reset after 7 accepts.
        send_range(0, 6, 0);
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("reset_async", {in_ready, wr_en, wr_addr, wr_re, wr_im,
                            flag, busy}, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        @(negedge clk);
        chk("reset_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        chk("reset_ready_high", in_ready, 1);
        #1;
        wq.delete();
        send_range(0, 15, 0);
        post_frame("after_reset");
        check_wq("after_reset");
        in_valid = 0;
        pulse_done(1);

        // Random traffic checked by the model every cycle.
        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_re = 16'($urandom);
            in_im = 16'($urandom);
            fft_done = ($urandom_range(0, 5) == 0);
            @(posedge clk);
            #2;
        end
        in_valid = 0;
        fft_done = 0;
        repeat (5) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Upstream loading stage for the in-place radix-2 FFT core. It accepts a stream of complex samples over a valid/ready handshake and sign-extends each to the core's internal width. Each sample is written into the shared data RAM at its bit-reversed address. After a full frame of N samples is stored, it pulses the FFT controller's start input, then holds off new input until the controller reports completion.

## Interface
Parameters:
- bit_width, 29, signed internal data width written to RAM
- in_width, 16, signed width of incoming samples
- SHIFT, 0, left-shift applied after sign extension; in_width+SHIFT <= bit_width
- N, 16, samples per frame, equal to 1<<SIZE
- SIZE, 4, log2(N)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample present on in_re/in_im
- in_ready  out  1  loader can accept a sample this cycle
- in_re  in  in_width  signed real part
- in_im  in  in_width  signed imaginary part
- fft_done  in  1  completion pulse from the FFT controller (its done_o)
- wr_en  out  1  RAM write enable
- wr_addr  out  SIZE+1  RAM write address; MSB is always 0
- wr_re  out  bit_width  signed real data to RAM
- wr_im  out  bit_width  signed imaginary data to RAM
- flag_start_FFT  out  1  one-cycle start pulse to the FFT controller
- busy  out  1  frame handed to FFT, input locked

## Operation
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- States: LOAD, FLUSH, START, BUSY. Reset enters LOAD.
- Accept condition: in_valid && in_ready, sampled on the rising edge.
- Sample counter cnt is SIZE bits wide and is cleared by reset and on leaving BUSY.
- LOAD:
  - Each accept registers wr_en=1, wr_addr={1'b0, bitreverse(cnt)}, wr_re=sext(in_re)<<SHIFT, wr_im=sext(in_im)<<SHIFT, then increments cnt.
  - A cycle with no accept registers wr_en=0. wr_addr and wr_re/wr_im hold their values.
  - Accepting the sample with cnt==N-1 moves to FLUSH, and in_ready is registered low at that same edge.
- FLUSH: the last write is on the bus (wr_en=1). The next state is START.
- START: wr_en=0 and flag_start_FFT=1 for exactly one cycle. The next state is BUSY.
- BUSY:
  - in_ready=0, busy=1, flag_start_FFT=0.
  - When fft_done is sampled high: return to LOAD, clear cnt, register in_ready=1, busy=0.
- fft_done in LOAD, FLUSH or START is ignored.
- A held fft_done causes only one return; the loader does not re-enter BUSY without a new frame.
- Arithmetic: sign extension is an MSB replicate to bit_width, followed by a logical left shift of SHIFT with zero fill. There is no saturation, and the parameter constraint guarantees no overflow.
- cnt wraps from N-1 to 0 only through the FLUSH path. No accept is possible while cnt==N-1 outside LOAD.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_re=0, wr_im=0, flag_start_FFT=0, busy=0, state=LOAD, cnt=0.
- in_ready is registered. It rises on the first clock edge after rst_n deasserts.
- Write latency: a sample accepted at edge t appears on wr_en/wr_addr/wr_re/wr_im during cycle t+1.
- Start latency: the final accept at edge t gives the last write in cycle t+1, flag_start_FFT high in cycle t+2, and busy high from cycle t+3.
- With in_valid held high, a full frame takes N accepts in N consecutive cycles. The start pulse appears N+1 cycles after the first accept.
- Bubbles in in_valid stall cnt without any other effect.
- Return from BUSY: fft_done sampled at edge t makes in_ready=1 and busy=0 during cycle t+1.
- Reset mid-operation: all outputs return to reset values immediately. A partial frame is discarded and the next frame restarts at cnt=0. RAM contents are not cleared.

## Test plan
- Continuous frame: in_re=k, in_im=-k for k=0..15, in_valid held high. Required writes: addresses 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 in that order, with wr_re=k and wr_im=-k. flag_start_FFT is high exactly 2 cycles after the 16th accept, and in_ready is 0 thereafter.
- Backpressure/bubbles: in_valid toggling 1,0,0,1,… Required: wr_en only in cycles following accepts, the same address sequence as above, and no start pulse until 16 accepts have occurred.
- Sign extension and shift:
  - SHIFT=0, in_re=16'h8000 → wr_re=29'h1FFF8000; in_im=16'h7FFF → wr_im=29'h00007FFF.
  - SHIFT=2, in_re=16'hFFFF → wr_re=29'h1FFFFFFC.
- Lockout and done: in_valid held high during BUSY produces no writes and in_ready stays 0. fft_done pulsed for 3 cycles gives exactly one return to LOAD. The second frame's first write goes to address 0.
- Spurious done: fft_done pulsed after 5 accepts in LOAD is ignored, and the frame completes normally after 11 more accepts.
- Reset mid-frame: rst_n pulsed low after 7 accepts. Outputs are zero immediately, in_ready returns 1 edge after release, and the next accept writes address 0.
